// File: rtl/reorder_buffer_initiator.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_initiator
// Purpose  : Tags in-order requests with ROB indices, routes out-of-order
//            responses into ROB writes and drains completions in order.
// Revision : 1.0  initial release
// ============================================================================
module reorder_buffer_initiator #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 8,
  parameter int INDEX_WIDTH = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   request_valid,
  output logic                   request_ready,
  input  logic [WIDTH-1:0]       request_data,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [WIDTH-1:0]       issue_data,
  output logic [INDEX_WIDTH-1:0] issue_tag,
  input  logic                   response_valid,
  output logic                   response_ready,
  input  logic [INDEX_WIDTH-1:0] response_tag,
  input  logic [WIDTH-1:0]       response_data,
  output logic                   completion_valid,
  input  logic                   completion_ready,
  output logic [WIDTH-1:0]       completion_data,
  output logic                   rob_reserve_enable,
  input  logic [INDEX_WIDTH-1:0] rob_reserve_index,
  input  logic                   rob_reserve_full,
  output logic                   rob_write_enable,
  output logic [INDEX_WIDTH-1:0] rob_write_index,
  output logic [WIDTH-1:0]       rob_write_data,
  input  logic                   rob_write_error,
  output logic                   rob_read_enable,
  input  logic [WIDTH-1:0]       rob_read_data,
  output logic [INDEX_WIDTH:0]   outstanding_count,
  output logic                   protocol_error
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [INDEX_WIDTH:0] c_one = {{INDEX_WIDTH{1'b0}}, 1'b1};

  logic [1:0]             r_state;
  logic [INDEX_WIDTH:0]   r_head;
  logic [INDEX_WIDTH:0]   r_tail;
  logic [DEPTH-1:0]       r_completed;
  logic [WIDTH-1:0]       r_completion_data;
  logic                   r_completion_valid;
  logic                   r_protocol_error;

  logic [INDEX_WIDTH-1:0] w_head_idx;
  logic [INDEX_WIDTH-1:0] w_offset;
  logic                   w_head_done;
  logic                   w_read;
  logic                   w_reserve;
  logic                   w_tag_live;
  logic                   w_resp_bad;

  // Issue path: zero-latency pass-through gated by ROB space
  assign issue_valid        = request_valid & ~rob_reserve_full;
  assign request_ready      = issue_ready & ~rob_reserve_full;
  assign w_reserve          = request_valid & request_ready;
  assign rob_reserve_enable = w_reserve;
  assign issue_tag          = rob_reserve_index;
  assign issue_data         = request_data;

  assign response_ready     = 1'b1;
  assign rob_write_enable   = response_valid;
  assign rob_write_index    = response_tag;
  assign rob_write_data     = response_data;

  // Pointers carry a wrap bit, so their difference spans 0..DEPTH (DEPTH is a power of two)
  assign outstanding_count  = r_tail - r_head;
  assign w_head_idx         = r_head[INDEX_WIDTH-1:0];
  assign w_head_done        = r_completed[w_head_idx];
  assign w_offset           = response_tag - w_head_idx;
  assign w_tag_live         = ({1'b0, w_offset} < outstanding_count);
  assign w_resp_bad         = response_valid & (~w_tag_live | r_completed[response_tag]);

  assign w_read = w_head_done &
                  ((r_state == S_EMPTY) | ((r_state == S_FULL) & completion_ready));
  assign rob_read_enable    = w_read;

  assign completion_valid   = r_completion_valid;
  assign completion_data    = r_completion_data;
  assign protocol_error     = r_protocol_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (w_read)    r_head <= r_head + c_one;
      if (w_reserve) r_tail <= r_tail + c_one;
    end
  end

  // Only legitimate responses mark an entry; a stray tag must not trigger a later drain
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_completed <= '0;
    end else begin
      if (w_read)                        r_completed[w_head_idx]   <= 1'b0;
      if (response_valid && !w_resp_bad) r_completed[response_tag] <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_protocol_error <= 1'b0;
    end else if (rob_write_error || w_resp_bad) begin
      r_protocol_error <= 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state            <= S_EMPTY;
      r_completion_valid <= 1'b0;
      r_completion_data  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_read) r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_completion_data  <= rob_read_data;
          r_completion_valid <= 1'b1;
          r_state            <= S_FULL;
        end
        S_FULL: begin
          if (completion_ready) begin
            r_completion_valid <= 1'b0;
            r_state            <= w_read ? S_FETCH : S_EMPTY;
          end
        end
        default: begin
          r_completion_valid <= 1'b0;
          r_state            <= S_EMPTY;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_reorder_buffer_initiator
// Purpose  : Scoreboard bench for reorder_buffer_initiator with a small ROB
//            controller model attached.
// Revision : 1.0  initial release
// ============================================================================
module tb_reorder_buffer_initiator;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int IW = 2;

  logic          clock;
  logic          reset;
  logic          request_valid, request_ready;
  logic [W-1:0]  request_data;
  logic          issue_valid, issue_ready;
  logic [W-1:0]  issue_data;
  logic [IW-1:0] issue_tag;
  logic          response_valid, response_ready;
  logic [IW-1:0] response_tag;
  logic [W-1:0]  response_data;
  logic          completion_valid, completion_ready;
  logic [W-1:0]  completion_data;
  logic          rob_reserve_enable;
  logic [IW-1:0] rob_reserve_index;
  logic          rob_reserve_full;
  logic          rob_write_enable;
  logic [IW-1:0] rob_write_index;
  logic [W-1:0]  rob_write_data;
  logic          rob_write_error;
  logic          rob_read_enable;
  logic [W-1:0]  rob_read_data;
  logic [IW:0]   outstanding_count;
  logic          protocol_error;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];

  reorder_buffer_initiator #(.WIDTH(W), .DEPTH(D), .INDEX_WIDTH(IW)) dut (
    .clock(clock), .reset(reset),
    .request_valid(request_valid), .request_ready(request_ready), .request_data(request_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_data(issue_data), .issue_tag(issue_tag),
    .response_valid(response_valid), .response_ready(response_ready),
    .response_tag(response_tag), .response_data(response_data),
    .completion_valid(completion_valid), .completion_ready(completion_ready),
    .completion_data(completion_data),
    .rob_reserve_enable(rob_reserve_enable), .rob_reserve_index(rob_reserve_index),
    .rob_reserve_full(rob_reserve_full),
    .rob_write_enable(rob_write_enable), .rob_write_index(rob_write_index),
    .rob_write_data(rob_write_data), .rob_write_error(rob_write_error),
    .rob_read_enable(rob_read_enable), .rob_read_data(rob_read_data),
    .outstanding_count(outstanding_count), .protocol_error(protocol_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reorder buffer controller model
  logic [W-1:0] m_mem [D];
  logic [IW:0]  m_tail, m_head;
  logic         force_werr;

  assign rob_reserve_index = m_tail[IW-1:0];
  assign rob_reserve_full  = ((m_tail - m_head) == (IW+1)'(D));
  assign rob_write_error   = force_werr;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_tail        <= '0;
      m_head        <= '0;
      rob_read_data <= '0;
    end else begin
      if (rob_reserve_enable) m_tail <= m_tail + 1'b1;
      if (rob_write_enable)   m_mem[rob_write_index] <= rob_write_data;
      if (rob_read_enable) begin
        rob_read_data <= m_mem[m_head[IW-1:0]];
        m_head        <= m_head + 1'b1;
      end
    end
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Completion monitor: handshake seen at negedge completes on the next rising edge
  always @(negedge clock) begin
    if (!reset && completion_valid && completion_ready) begin
      check_value("completion_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check_value("completion_data", completion_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_req(input logic [W-1:0] d, input logic [IW-1:0] exp_tag);
    request_valid = 1'b1;
    request_data  = d;
    #1;
    check_value("issue_valid", issue_valid, 1);
    check_value("issue_tag", issue_tag, exp_tag);
    check_value("issue_data", issue_data, d);
    tick();
    request_valid = 1'b0;
  endtask

  task automatic respond(input logic [IW-1:0] t, input logic [W-1:0] d);
    response_valid = 1'b1;
    response_tag   = t;
    response_data  = d;
    tick();
    response_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    check_value(tag, exp_q.size(), 0);
  endtask

  task automatic do_reset();
    tick();
    reset          = 1'b1;
    request_valid  = 1'b0;
    response_valid = 1'b0;
    force_werr     = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; request_valid = 1'b0; request_data = '0; issue_ready = 1'b0;
    response_valid = 1'b0; response_tag = '0; response_data = '0;
    completion_ready = 1'b0; force_werr = 1'b0;
    #12;
    check_value("rst_issue_valid", issue_valid, 0);
    check_value("rst_request_ready", request_ready, 0);
    check_value("rst_response_ready", response_ready, 1);
    check_value("rst_completion_valid", completion_valid, 0);
    check_value("rst_read_enable", rob_read_enable, 0);
    check_value("rst_count", outstanding_count, 0);
    check_value("rst_error", protocol_error, 0);
    issue_ready = 1'b1;
    completion_ready = 1'b1;
    tick();
    reset = 1'b0;

    // Single request, two-cycle completion latency
    issue_req(8'h11, 0);
    check_value("t1_count_up", outstanding_count, 1);
    exp_q.push_back(8'h22);
    respond(0, 8'h22);
    check_value("t1_read_enable", rob_read_enable, 1);
    tick();
    check_value("t1_count_down", outstanding_count, 0);
    check_value("t1_fetch_valid", completion_valid, 0);
    tick();
    check_value("t1_valid", completion_valid, 1);
    check_value("t1_data", completion_data, 8'h22);
    wait_drain("t1_drain");

    // Out-of-order responses complete in order
    do_reset();
    for (int i = 0; i < 3; i++) issue_req(8'hB0 + 8'(i), IW'(i));
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    respond(2, 8'hA2);
    respond(0, 8'hA0);
    respond(1, 8'hA1);
    wait_drain("ooo_drain");
    check_value("ooo_count", outstanding_count, 0);
    check_value("ooo_error", protocol_error, 0);

    // Full ROB, then wrap-around
    do_reset();
    for (int i = 0; i < 4; i++) issue_req(8'hC0 + 8'(i), IW'(i));
    request_valid = 1'b1;
    #1;
    check_value("full_flag", rob_reserve_full, 1);
    check_value("full_ready", request_ready, 0);
    check_value("full_issue_valid", issue_valid, 0);
    check_value("full_count", outstanding_count, 4);
    request_valid = 1'b0;
    exp_q.push_back(8'h30);
    respond(0, 8'h30);
    wait_drain("full_drain1");
    check_value("full_ready_back", request_ready, 1);
    check_value("full_count3", outstanding_count, 3);
    issue_req(8'hC4, 0);
    exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h33); exp_q.push_back(8'h35);
    respond(3, 8'h33);
    respond(0, 8'h35);
    respond(1, 8'h31);
    respond(2, 8'h32);
    wait_drain("wrap_drain");
    check_value("wrap_count", outstanding_count, 0);
    check_value("wrap_error", protocol_error, 0);

    // Backpressure holds the completion stable
    do_reset();
    completion_ready = 1'b0;
    issue_req(8'hD0, 0);
    issue_req(8'hD1, 1);
    exp_q.push_back(8'h40); exp_q.push_back(8'h41);
    respond(0, 8'h40);
    respond(1, 8'h41);
    begin
      int n = 0;
      while (!completion_valid && n < 20) begin
        tick();
        n++;
      end
    end
    check_value("bp_valid_seen", completion_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check_value("bp_valid", completion_valid, 1);
      check_value("bp_data", completion_data, 8'h40);
      check_value("bp_no_read", rob_read_enable, 0);
      check_value("bp_count", outstanding_count, 1);
      tick();
    end
    completion_ready = 1'b1;
    wait_drain("bp_drain");

    // Duplicate response
    do_reset();
    issue_req(8'hE0, 0);
    issue_req(8'hE1, 1);
    respond(1, 8'h51);
    check_value("dup_clean", protocol_error, 0);
    respond(1, 8'h52);
    check_value("dup_error", protocol_error, 1);
    tick(); tick(); tick();
    check_value("dup_sticky", protocol_error, 1);

    // Response to an unreserved tag
    do_reset();
    check_value("err_cleared", protocol_error, 0);
    issue_req(8'hE2, 0);
    respond(3, 8'h53);
    check_value("unres_error", protocol_error, 1);

    // Controller-reported write error
    do_reset();
    force_werr = 1'b1;
    tick();
    force_werr = 1'b0;
    check_value("werr_error", protocol_error, 1);

    // Asynchronous reset mid-stream
    do_reset();
    for (int i = 0; i < 3; i++) issue_req(8'hF0 + 8'(i), IW'(i));
    respond(1, 8'h60);
    #2;
    reset = 1'b1;
    #1;
    check_value("mid_rst_count", outstanding_count, 0);
    check_value("mid_rst_valid", completion_valid, 0);
    check_value("mid_rst_read", rob_read_enable, 0);
    check_value("mid_rst_error", protocol_error, 0);
    tick();
    reset = 1'b0;
    issue_req(8'h61, 0);
    issue_req(8'h62, 1);
    exp_q.push_back(8'h63);
    respond(0, 8'h63);
    wait_drain("mid_rst_drain");
    tick(); tick(); tick();
    check_value("mid_rst_stale", outstanding_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
